mem_bus_arbiter: RTL and testbench

- Shares the core's single memory bus between instruction fetch and the memory-stage data port.
- Sequences each transaction with a small FSM and returns registered responses to the requester.
- Produces the `handshake_stall` that freezes the pipeline registers while any request is outstanding.
- Keeps a stall-cycle counter and a sticky watchdog timeout.

---
 rtl/mem_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fetch/data arbiter for the single core memory bus
// Data has fixed priority; a flushed fetch drains on the bus instead of aborting.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              iresp_ok,
  output logic [31:0]       iresp_data,
  input  logic              dreq_valid,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [7:0]        dreq_strobe,
  input  logic [DATA_W-1:0] dreq_wdata,
  output logic              dresp_ok,
  output logic [DATA_W-1:0] dresp_data,
  output logic              bus_valid,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_strobe,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              csr_flush,
  output logic              handshake_stall,
  output logic [31:0]       stall_cycles,
  output logic              timeout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        strobe_q, strobe_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              iresp_ok_q, iresp_ok_d;
  logic              dresp_ok_q, dresp_ok_d;
  logic [31:0]       iresp_data_q, iresp_data_d;
  logic [DATA_W-1:0] dresp_data_q, dresp_data_d;
  logic [31:0]       stall_cycles_q, stall_cycles_d;
  logic              timeout_q, timeout_d;

  assign handshake_stall = (ireq_valid & ~iresp_ok_q) | (dreq_valid & ~dresp_ok_q)
                         | (state_q == DRAIN);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    strobe_d     = strobe_q;
    wdata_d      = wdata_q;
    iresp_ok_d   = 1'b0;
    dresp_ok_d   = 1'b0;
    iresp_data_d = iresp_data_q;
    dresp_data_d = dresp_data_q;
    case (state_q)
      IDLE: begin
        // The cycle carrying resp_ok still sees the old request held high; never regrant it.
        if (!(iresp_ok_q || dresp_ok_q)) begin
          if (dreq_valid) begin
            state_d  = GNT_D;
            addr_d   = dreq_addr;
            strobe_d = dreq_strobe;
            wdata_d  = dreq_wdata;
          end else if (ireq_valid) begin
            state_d  = GNT_I;
            addr_d   = ireq_addr;
            strobe_d = '0;
            wdata_d  = '0;
          end
        end
      end
      GNT_I: begin
        if (bus_ok) begin
          state_d = IDLE;
          if (!csr_flush) begin
            iresp_ok_d   = 1'b1;
            iresp_data_d = addr_q[2] ? bus_rdata[63:32] : bus_rdata[31:0];
          end
        end else if (csr_flush) begin
          state_d = DRAIN;
        end
      end
      GNT_D: begin
        if (bus_ok) begin
          state_d      = IDLE;
          dresp_ok_d   = 1'b1;
          dresp_data_d = bus_rdata;
        end
      end
      default: begin
        if (bus_ok) state_d = IDLE;
      end
    endcase

    if (!handshake_stall)                  stall_cycles_d = '0;
    else if (stall_cycles_q == 32'hFFFF_FFFF) stall_cycles_d = stall_cycles_q;
    else                                   stall_cycles_d = stall_cycles_q + 32'd1;
    timeout_d = timeout_q | (handshake_stall && (stall_cycles_q == TIMEOUT_M1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      strobe_q       <= '0;
      wdata_q        <= '0;
      iresp_ok_q     <= 1'b0;
      dresp_ok_q     <= 1'b0;
      iresp_data_q   <= '0;
      dresp_data_q   <= '0;
      stall_cycles_q <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      strobe_q       <= strobe_d;
      wdata_q        <= wdata_d;
      iresp_ok_q     <= iresp_ok_d;
      dresp_ok_q     <= dresp_ok_d;
      iresp_data_q   <= iresp_data_d;
      dresp_data_q   <= dresp_data_d;
      stall_cycles_q <= stall_cycles_d;
      timeout_q      <= timeout_d;
    end
  end

  assign bus_valid    = (state_q != IDLE);
  assign bus_addr     = addr_q;
  assign bus_strobe   = strobe_q;
  assign bus_wdata    = wdata_q;
  assign iresp_ok     = iresp_ok_q;
  assign dresp_ok     = dresp_ok_q;
  assign iresp_data   = iresp_data_q;
  assign dresp_data   = dresp_data_q;
  assign stall_cycles = stall_cycles_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed bench for mem_bus_arbiter
// A transaction-level reference (owner/drain flags) is compared every cycle, plus literal spot checks.
module tb_mem_bus_arbiter;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ireq_valid = 1'b0;
  logic [63:0] ireq_addr = '0;
  logic        iresp_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid = 1'b0;
  logic [63:0] dreq_addr = '0;
  logic [7:0]  dreq_strobe = '0;
  logic [63:0] dreq_wdata = '0;
  logic        dresp_ok;
  logic [63:0] dresp_data;
  logic        bus_valid;
  logic [63:0] bus_addr;
  logic [7:0]  bus_strobe;
  logic [63:0] bus_wdata;
  logic        bus_ok = 1'b0;
  logic [63:0] bus_rdata = '0;
  logic        csr_flush = 1'b0;
  logic        handshake_stall;
  logic [31:0] stall_cycles;
  logic        timeout;

  int n_vec = 0;
  int n_err = 0;
  bit started = 1'b0;

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_ok(iresp_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe),
    .dreq_wdata(dreq_wdata), .dresp_ok(dresp_ok), .dresp_data(dresp_data),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_strobe(bus_strobe),
    .bus_wdata(bus_wdata), .bus_ok(bus_ok), .bus_rdata(bus_rdata),
    .csr_flush(csr_flush), .handshake_stall(handshake_stall),
    .stall_cycles(stall_cycles), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: who owns the bus, whether a flushed fetch is draining, and the reply pulses.
  int          m_owner = 0;  // 0 none, 1 fetch, 2 data
  bit          m_drain = 0;
  logic [63:0] m_addr = '0, m_wdata = '0, m_ddata = '0;
  logic [7:0]  m_strobe = '0;
  logic [31:0] m_idata = '0;
  bit          m_iok = 0, m_dok = 0, m_to = 0;
  longint      m_cnt = 0;

  function automatic bit exp_stall();
    return (ireq_valid && !m_iok) || (dreq_valid && !m_dok) || m_drain;
  endfunction

  always @(posedge clk) begin
    bit st, had_reply;
    if (!reset) begin
      m_owner = 0; m_drain = 0; m_iok = 0; m_dok = 0; m_to = 0; m_cnt = 0;
      m_idata = '0; m_ddata = '0;
    end else begin
      st = exp_stall();
      if (st && m_cnt == TO - 1) m_to = 1;
      m_cnt = st ? ((m_cnt < 64'hFFFF_FFFF) ? m_cnt + 1 : m_cnt) : 0;
      had_reply = m_iok || m_dok;
      m_iok = 0;
      m_dok = 0;
      if (m_owner == 0) begin
        if (!had_reply && dreq_valid) begin
          m_owner = 2; m_addr = dreq_addr; m_strobe = dreq_strobe; m_wdata = dreq_wdata;
        end else if (!had_reply && ireq_valid) begin
          m_owner = 1; m_addr = ireq_addr; m_strobe = '0; m_wdata = '0;
        end
      end else if (bus_ok) begin
        if (m_owner == 2) begin
          m_dok = 1; m_ddata = bus_rdata;
        end else if (!m_drain && !csr_flush) begin
          m_iok = 1; m_idata = m_addr[2] ? bus_rdata[63:32] : bus_rdata[31:0];
        end
        m_owner = 0;
        m_drain = 0;
      end else if (m_owner == 1 && csr_flush) begin
        m_drain = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("bus_valid", 64'(bus_valid), 64'(m_owner != 0));
      if (m_owner != 0) begin
        check("bus_addr", bus_addr, m_addr);
        check("bus_strobe", 64'(bus_strobe), 64'(m_strobe));
        check("bus_wdata", bus_wdata, m_wdata);
      end
      check("iresp_ok", 64'(iresp_ok), 64'(m_iok));
      check("iresp_data", 64'(iresp_data), 64'(m_idata));
      check("dresp_ok", 64'(dresp_ok), 64'(m_dok));
      check("dresp_data", dresp_data, m_ddata);
      check("stall", 64'(handshake_stall), 64'(exp_stall()));
      check("stall_cycles", 64'(stall_cycles), 64'(m_cnt));
      check("timeout", 64'(timeout), 64'(m_to));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with a fetch pending
    ireq_valid = 1; ireq_addr = 64'h8000_0000;
    tick(); started = 1;
    tick(); tick();
    check("rst_bus_valid", 64'(bus_valid), 64'd0);
    check("rst_stall_cycles", 64'(stall_cycles), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    reset = 1;
    tick();
    check("rel_bus_valid", 64'(bus_valid), 64'd1);
    check("rel_bus_addr", bus_addr, 64'h8000_0000);
    bus_ok = 1; bus_rdata = 64'h1111_2222_3333_4444;
    tick(); bus_ok = 0; ireq_valid = 0;
    check("rel_iresp_data", 64'(iresp_data), 64'h3333_4444);
    tick();

    // Upper-word fetch
    ireq_valid = 1; ireq_addr = 64'h8000_0004;
    tick();
    check("f_bus_valid", 64'(bus_valid), 64'd1);
    bus_ok = 1; bus_rdata = 64'h0050_0093_0000_0013;
    tick(); bus_ok = 0; ireq_valid = 0;
    check("f_iresp_ok", 64'(iresp_ok), 64'd1);
    check("f_iresp_data", 64'(iresp_data), 64'h0050_0093);
    tick();
    check("f_iresp_pulse", 64'(iresp_ok), 64'd0);

    // Simultaneous requests: data first
    ireq_valid = 1; ireq_addr = 64'h8000_0008;
    dreq_valid = 1; dreq_addr = 64'h8000_1000; dreq_strobe = 8'hFF;
    dreq_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    check("c_bus_addr", bus_addr, 64'h8000_1000);
    check("c_bus_strobe", 64'(bus_strobe), 64'hFF);
    bus_ok = 1; bus_rdata = 64'h0123_4567_89AB_CDEF;
    tick(); bus_ok = 0; dreq_valid = 0;
    check("c_dresp_ok", 64'(dresp_ok), 64'd1);
    check("c_no_grant", 64'(bus_valid), 64'd0);
    tick();
    check("c_stall_held", 64'(handshake_stall), 64'd1);
    tick();
    check("c_i_grant", bus_addr, 64'h8000_0008);
    bus_ok = 1; bus_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    tick(); bus_ok = 0; ireq_valid = 0;
    check("c_iresp_data", 64'(iresp_data), 64'hCCCC_DDDD);
    tick();

    // Flush during fetch, bus_ok three cycles later
    ireq_valid = 1; ireq_addr = 64'h8000_0010;
    tick();
    csr_flush = 1;
    tick(); csr_flush = 0; ireq_valid = 0;
    tick(); tick();
    check("fl_drain_valid", 64'(bus_valid), 64'd1);
    check("fl_drain_stall", 64'(handshake_stall), 64'd1);
    bus_ok = 1; bus_rdata = 64'h5555_6666_7777_8888;
    tick(); bus_ok = 0;
    check("fl_no_iresp", 64'(iresp_ok), 64'd0);
    check("fl_idle", 64'(bus_valid), 64'd0);
    tick();

    // Flush coinciding with bus_ok in fetch: dropped
    ireq_valid = 1; ireq_addr = 64'h8000_0014;
    tick();
    csr_flush = 1; bus_ok = 1;
    tick(); csr_flush = 0; bus_ok = 0; ireq_valid = 0;
    check("flok_no_iresp", 64'(iresp_ok), 64'd0);
    tick();

    // Flush during data access has no effect
    dreq_valid = 1; dreq_addr = 64'h8000_2000; dreq_strobe = 8'h00;
    tick();
    csr_flush = 1; bus_ok = 1; bus_rdata = 64'h0F0F_0F0F_F0F0_F0F0;
    tick(); csr_flush = 0; bus_ok = 0; dreq_valid = 0;
    check("fd_dresp_ok", 64'(dresp_ok), 64'd1);
    check("fd_dresp_data", dresp_data, 64'h0F0F_0F0F_F0F0_F0F0);
    tick();

    // Watchdog
    ireq_valid = 1; ireq_addr = 64'h8000_0020;
    repeat (15) tick();
    check("wd_cnt15", 64'(stall_cycles), 64'd15);
    check("wd_to_pre", 64'(timeout), 64'd0);
    tick();
    check("wd_cnt16", 64'(stall_cycles), 64'd16);
    check("wd_to_set", 64'(timeout), 64'd1);
    repeat (4) tick();
    bus_ok = 1;
    tick(); bus_ok = 0; ireq_valid = 0;
    tick();
    check("wd_cnt_clr", 64'(stall_cycles), 64'd0);
    check("wd_sticky", 64'(timeout), 64'd1);

    // Reset mid data transaction
    dreq_valid = 1; dreq_addr = 64'h8000_3000; dreq_strobe = 8'h0F;
    tick();
    reset = 0; dreq_valid = 0;
    tick();
    reset = 1; bus_ok = 1;
    check("mr_bus_valid", 64'(bus_valid), 64'd0);
    check("mr_timeout", 64'(timeout), 64'd0);
    check("mr_dresp_data", dresp_data, 64'd0);
    tick(); bus_ok = 0;
    check("mr_no_dresp", 64'(dresp_ok), 64'd0);
    check("mr_idle", 64'(bus_valid), 64'd0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
